// File: rtl/even_count_pkg.sv
// Shared constants and state encoding for the even up/down counter checker.
package even_count_pkg;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned STEP    = 2;
  localparam int unsigned WRAP_HI = (1 << WIDTH) - 2;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

endpackage

// File: rtl/even_step_predict.sv
// Combinational next-value predictor for an even counter stepping by two.
module even_step_predict #(
  parameter int unsigned WIDTH = even_count_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] prev_count,
  input  logic             prev_dir,
  output logic [WIDTH-1:0] expected,
  output logic             is_wrap_up,
  output logic             is_wrap_dn
);
  import even_count_pkg::*;

  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] WRAP_TOP = {{(WIDTH-1){1'b1}}, 1'b0};

  always_comb begin
    expected   = prev_dir ? (prev_count + STEP_W) : (prev_count - STEP_W);
    is_wrap_up = prev_dir && (expected == '0);
    is_wrap_dn = !prev_dir && (expected == WRAP_TOP);
  end

endmodule

// File: rtl/even_count_checker.sv
// Receive-side monitor: tracks the even counter, predicts its next value and flags errors.
module even_count_checker #(
  parameter int unsigned WIDTH  = even_count_pkg::WIDTH,
  parameter int unsigned ERR_W  = 8,
  parameter bit          STICKY = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             dir_in,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic             err_odd,
  output logic             err_step,
  output logic             err_any,
  output logic [ERR_W-1:0] err_count
);
  import even_count_pkg::*;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  logic             prev_dir_q, prev_dir_d;
  logic             wrap_up_q, wrap_up_d, wrap_dn_q, wrap_dn_d;
  logic             err_odd_q, err_odd_d, err_step_q, err_step_d;
  logic             err_any_q, err_any_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             err_hit;

  logic [WIDTH-1:0] hold_exp;
  logic             hold_wrap_up, hold_wrap_dn;

  even_step_predict #(.WIDTH(WIDTH)) u_predict (
    .prev_count (prev_count_q),
    .prev_dir   (prev_dir_q),
    .expected   (hold_exp),
    .is_wrap_up (hold_wrap_up),
    .is_wrap_dn (hold_wrap_dn)
  );

  always_comb begin
    state_d      = state_q;
    prev_count_d = prev_count_q;
    prev_dir_d   = prev_dir_q;
    wrap_up_d    = 1'b0;
    wrap_dn_d    = 1'b0;
    err_odd_d    = 1'b0;
    err_step_d   = 1'b0;
    err_any_d    = STICKY ? err_any_q : 1'b0;
    err_count_d  = err_count_q;
    err_hit      = 1'b0;

    if (sample_en) begin
      unique case (state_q)
        UNLOCKED: begin
          if (count_in[0]) begin
            err_odd_d = 1'b1;
            err_hit   = 1'b1;
          end else begin
            prev_count_d = count_in;
            prev_dir_d   = dir_in;
            state_d      = LOCKED;
          end
        end
        LOCKED: begin
          if (count_in[0]) begin
            // Odd while locked is one erroneous sample carrying both flags.
            err_odd_d  = 1'b1;
            err_step_d = 1'b1;
            err_hit    = 1'b1;
            state_d    = UNLOCKED;
          end else begin
            prev_count_d = count_in;
            prev_dir_d   = dir_in;
            if (count_in != hold_exp) begin
              err_step_d = 1'b1;
              err_hit    = 1'b1;
            end else begin
              wrap_up_d = hold_wrap_up;
              wrap_dn_d = hold_wrap_dn;
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase

      if (err_hit) begin
        err_any_d = 1'b1;
        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= UNLOCKED;
      prev_count_q <= '0;
      prev_dir_q   <= 1'b0;
      wrap_up_q    <= 1'b0;
      wrap_dn_q    <= 1'b0;
      err_odd_q    <= 1'b0;
      err_step_q   <= 1'b0;
      err_any_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_count_q <= prev_count_d;
      prev_dir_q   <= prev_dir_d;
      wrap_up_q    <= wrap_up_d;
      wrap_dn_q    <= wrap_dn_d;
      err_odd_q    <= err_odd_d;
      err_step_q   <= err_step_d;
      err_any_q    <= err_any_d;
      err_count_q  <= err_count_d;
    end
  end

  // The prediction is a pure function of the held reference, so it is gated rather than re-registered.
  always_comb begin
    locked    = (state_q == LOCKED);
    expected  = locked ? hold_exp : '0;
    wrap_up   = wrap_up_q;
    wrap_dn   = wrap_dn_q;
    err_odd   = err_odd_q;
    err_step  = err_step_q;
    err_any   = err_any_q;
    err_count = err_count_q;
  end

endmodule

// File: doc/even_count_checker.md
Name: even_count_checker

Overview:
Receive-side monitor for the 4-bit even up/down counter (outputs A,B,C,D with D as LSB; direction input Y, where 1 = up and 0 = down; step of 2).
- Samples the counter value and the direction applied to it on every enabled clock.
- Predicts the next legal value and flags illegal steps, odd values and wrap events.
- Keeps a saturating error count. Sits beside the counter in lab benches and self-checking top levels.

Parameters:
WIDTH, 4, counter width in bits; LSB must always be 0.
ERR_W, 8, width of the saturating error counter.
STICKY, 0, 1 = err_any stays high until reset; 0 = err_any pulses per error.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high; clears all state on the rising edge of clock.
sample_en  in  1  1 = count_in/dir_in are valid this cycle.
count_in  in  WIDTH  counter value {A,B,C,D}, D = LSB.
dir_in  in  1  direction (Y) driven into the counter for its next edge.
locked  out  1  a legal reference sample is held.
expected  out  WIDTH  predicted next value (valid when locked).
wrap_up  out  1  one-cycle pulse: legal 14 -> 0 step seen.
wrap_dn  out  1  one-cycle pulse: legal 0 -> 14 step seen.
err_odd  out  1  one-cycle pulse: sample had LSB = 1.
err_step  out  1  one-cycle pulse: sample != expected while locked.
err_any  out  1  err_odd | err_step (sticky if STICKY = 1).
err_count  out  ERR_W  number of erroneous samples, saturating.

Behaviour:
- All outputs are registered and update on the clock edge where sample_en = 1. Latency is 1 cycle from sample to flag.
- Pulse outputs (wrap_up, wrap_dn, err_odd, err_step; err_any when STICKY = 0) are 0 in any cycle following an edge with sample_en = 0.
- Reset: locked = 0, expected = 0, all pulses = 0, err_any = 0, err_count = 0, state = UNLOCKED. Reset has priority over sample_en. Reset asserted mid-run discards the held reference; the next sample re-primes.
- Internal registers: prev_count[WIDTH], prev_dir, state.
- Prediction: expected = prev_count + 2 when prev_dir = 1, else prev_count - 2. Arithmetic is modulo 2^WIDTH, so 14 + 2 = 0 and 0 - 2 = 14 for WIDTH = 4.
- Direction use: dir_in is captured with each sample and governs the *following* step. A direction change takes effect one sample later.

State UNLOCKED, on a sample:
- If count_in is even: store prev_count = count_in and prev_dir = dir_in; go to LOCKED. No step check.
- If count_in is odd: err_odd = 1, err_count += 1, stay UNLOCKED.

State LOCKED, on a sample:
- Odd count_in: err_odd = 1 and err_step = 1, counted once. Go to UNLOCKED.
- Even count_in != expected: err_step = 1, err_count += 1. Re-anchor (prev_count = count_in, prev_dir = dir_in) and stay LOCKED.
- count_in == expected: legal step, no error; update prev_count and prev_dir.
  - wrap_up = 1 if prev_dir = 1 and count_in = 0.
  - wrap_dn = 1 if prev_dir = 0 and count_in = 2^WIDTH - 2.
- Outputs locked and expected reflect the state after the edge.

Other rules:
- err_count saturates at 2^ERR_W - 1; further errors leave it unchanged.
- Without sample_en, the state and held reference are unchanged indefinitely.
- A constant value is not a legal step (the counter always moves) and raises err_step.

Decomposition:
- Shared package even_count_pkg holds: WIDTH default, STEP = 2, WRAP_HI = 2^WIDTH - 2, and the state encoding (UNLOCKED = 0, LOCKED = 1).
- One sub-module, even_step_predict: combinational; takes prev_count and prev_dir; outputs expected, is_wrap_up and is_wrap_dn.
- The checker FSM, registers and error counter stay in even_count_checker.

Test Plan:
1. Reset, then samples 0,2,4,6 with dir_in = 1 -> locked = 1 after the first sample; expected goes 2,4,6,8; no error pulses; err_count = 0.
2. Up wrap: samples 12,14,0 with dir_in = 1 -> wrap_up pulses exactly one cycle after sample 0; expected = 2; no errors.
3. Down wrap with direction change: samples 2 (dir = 0), 0 (dir = 0), 14 (dir = 1), 0 -> wrap_dn after 14; the following 0 is legal (up step); no errors.
4. Skip and odd: samples 4,8 (dir = 1) -> err_step, err_count = 1, expected = 10. Then sample 5 -> err_odd = err_step = 1, err_count = 2, locked = 0. Then 6 -> re-locks with no error.
5. Saturation and sticky: ERR_W = 2, STICKY = 1; inject 5 odd samples -> err_count stops at 3; err_any stays 1 with sample_en = 0.
6. Reset mid-run while locked at 10 with err_count = 2 -> next cycle locked = 0, err_count = 0, err_any = 0. Sample 7 then raises only err_odd, not err_step.
